i2c_cfg_slave: RTL
==================

// Module: i2c_cfg_slave
// PURPOSE
//  I2C target (responder) at the far end of the configuration master's bus. Serves as an
//  FPGA-resident codec/decoder register stand-in and as a bench target.
//  Decodes [SLAVE_ADDR, SUB_ADDR, DATA...] write frames into an internal 8-bit register file.
//  Emits a one-cycle write strobe per data byte and exposes a host-side read port.
// PARAMETERS
//  DEV_ADDR   7'h1A  7-bit device address; write frame byte 0 = 8'h34
//  REG_DEPTH  16     register file entries; valid sub-addresses are 0..REG_DEPTH-1
// PORTS
//  CLOCK_50   in     1  system clock, all logic on rising edge
//  iRST_N     in     1  reset, synchronous, active-low
//  I2C_SCLK   in     1  bus clock from master (asynchronous to CLOCK_50)
//  I2C_SDAT   inout  1  bus data, open-drain: driven 0 or 1'bz only
//  iRD_ADDR   in     8  host read address
//  oRD_DATA   out    8  reg[iRD_ADDR], registered, 1-cycle latency; 0 if address out of range
//  oWR_STB    out    1  one-cycle pulse per accepted data byte
//  oWR_ADDR   out    8  register address of the last write; valid with oWR_STB, held after
//  oWR_DATA   out    8  data of the last write; valid with oWR_STB, held after
//  oBUSY      out    1  high from START to STOP while addressed
// BEHAVIOUR
//  - Reset (iRST_N=0 at clock edge) sets every output to 0, SDA released (z),
//    state IDLE, pointer 0, all registers 0. Reset mid-frame aborts the frame with no write.
//  - SCL/SDA: 2-flop synchroniser plus edge register, giving 3 CLOCK_50 cycles pin-to-event.
//  - START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both take precedence
//    over data bits.
//  - Data bits are sampled on SCL rise, MSB first. A 3-bit counter tracks the bit; byte
//    complete on the 8th rise.
//  - States: IDLE, DEV, DEV_ACK, SUB, SUB_ACK, DAT, DAT_ACK, IGNORE
//    (plus RD, RD_ACK with option).
//  - IDLE --START--> DEV. STOP in any state -> IDLE, SDA released, oBUSY=0.
//  - Repeated START in any state -> DEV with the bit counter cleared.
//  - DEV: byte[7:1]==DEV_ADDR and byte[0]==0 -> DEV_ACK, oBUSY=1.
//    Otherwise -> IGNORE: no SDA drive until the next START or STOP.
//  - ACK timing: SDA is pulled low on the SCL fall after the 8th rise, and released on the
//    following SCL fall.
//  - SUB: byte < REG_DEPTH -> latch into the pointer and go to SUB_ACK.
//    Otherwise NACK (SDA not driven) and -> IGNORE.
//  - DAT: write reg[ptr] <= byte. Update oWR_ADDR=ptr and oWR_DATA=byte, pulse oWR_STB in the
//    CLOCK_50 cycle the ACK drive starts, then go to DAT_ACK.
//  - After each data byte ptr increments, wrapping REG_DEPTH-1 -> 0. Burst length is unbounded.
//  - A partial byte (STOP/START before the 8th rise) is discarded: no write, no strobe.
//  - A host read and a bus write to the same address in the same cycle: oRD_DATA returns the
//    old value; the new value appears next cycle.
// CONFIGURATION
//  I2C_SLAVE_READ_EN defined:
//  - DEV byte with R/W=1 and matching address is ACKed, then the block enters RD.
//  - RD shifts reg[ptr] MSB-first; SDA changes only on SCL fall (0 driven, 1 = z).
//  - RD_ACK samples the master: ACK -> ptr++ (wrapping) and next byte; NACK -> IGNORE.
//  - No oWR_STB pulses during reads.
//  I2C_SLAVE_READ_EN undefined:
//  - R/W=1 is treated as an address mismatch: NACK, then IGNORE. RD states are not built.
// TESTING
//  1. Write 34,07,4D, STOP -> three ACKs; one oWR_STB with ADDR=07, DATA=4D;
//     iRD_ADDR=07 gives oRD_DATA=4D.
//  2. Write 40,07,4D -> SDA high at 9th SCL; no strobe; oBUSY stays 0; registers unchanged.
//  3. Write 34,0F,AA,BB -> reg15=AA, reg0=BB (wrap); two strobes.
//  4. Write 34,20,55 with REG_DEPTH=16 -> byte-1 ACK, byte-2 NACK; no strobe.
//  5. STOP after 4 bits of data -> no write; next frame 34,01,11 -> reg1=11.
//     Reset during a DAT_ACK drive -> SDA z in the next cycle.
//  6. READ_EN: 34,03,Sr,35, read 2 bytes (ACK, NACK) with reg3=12, reg4=34 -> returns 12, 34.
//     Without READ_EN: 35 NACKed.

Source files
------------

// File: rtl/i2c_cfg_slave.sv
// I2C write target: [addr, sub, data...] frames land in an 8-bit register file with a host read port.
// Bus reads of the register file are built only when I2C_SLAVE_READ_EN is defined.
module i2c_cfg_slave #(
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         REG_DEPTH = 16
) (
    input  logic       CLOCK_50,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    input  logic [7:0] iRD_ADDR,
    output logic [7:0] oRD_DATA,
    output logic       oWR_STB,
    output logic [7:0] oWR_ADDR,
    output logic [7:0] oWR_DATA,
    output logic       oBUSY
);

    localparam int            PW       = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam logic [8:0]    DEPTH    = 9'(REG_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(REG_DEPTH - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV, S_DEV_ACK, S_SUB, S_SUB_ACK, S_DAT, S_DAT_ACK, S_IGNORE
`ifdef I2C_SLAVE_READ_EN
        , S_RD, S_RD_ACK
`endif
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    scl_sync, sda_sync;
    logic          scl_q, sda_q;
    logic          scl, sda, scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]    bit_cnt;
    logic          byte_full;
    logic [7:0]    shreg;
    logic [PW-1:0] ptr, ptr_inc;
    logic [7:0]    regs [REG_DEPTH];
    logic          dev_match, sub_ok, wr_en, counting, sda_low;
`ifdef I2C_SLAVE_READ_EN
    logic          rw;
    logic [7:0]    tx;
    logic          ack_n;
`endif

    // Two sync flops, then an edge register; idle-high reset avoids false edges.
    always_ff @(posedge CLOCK_50) begin
        if (!iRST_N) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], I2C_SCLK};
            sda_sync <= {sda_sync[0], I2C_SDAT};
            scl_q    <= scl_sync[1];
            sda_q    <= sda_sync[1];
        end
    end

    assign scl       = scl_sync[1];
    assign sda       = sda_sync[1];
    assign scl_rise  = scl & ~scl_q;
    assign scl_fall  = ~scl & scl_q;
    assign start_det = scl & scl_q & sda_q & ~sda;
    assign stop_det  = scl & scl_q & ~sda_q & sda;

`ifdef I2C_SLAVE_READ_EN
    assign dev_match = (shreg[7:1] == DEV_ADDR);
`else
    assign dev_match = (shreg[7:1] == DEV_ADDR) && !shreg[0];
`endif
    assign sub_ok  = ({1'b0, shreg} < DEPTH);
    assign ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;

    always_ff @(posedge CLOCK_50) begin
        if (!iRST_N) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start_det) begin
            state_nx = S_DEV;
        end else if (stop_det) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_DEV:     if (scl_fall && byte_full) state_nx = dev_match ? S_DEV_ACK : S_IGNORE;
                S_DEV_ACK: if (scl_fall) begin
`ifdef I2C_SLAVE_READ_EN
                    state_nx = rw ? S_RD : S_SUB;
`else
                    state_nx = S_SUB;
`endif
                end
                S_SUB:     if (scl_fall && byte_full) state_nx = sub_ok ? S_SUB_ACK : S_IGNORE;
                S_SUB_ACK: if (scl_fall) state_nx = S_DAT;
                S_DAT:     if (scl_fall && byte_full) state_nx = S_DAT_ACK;
                S_DAT_ACK: if (scl_fall) state_nx = S_DAT;
`ifdef I2C_SLAVE_READ_EN
                S_RD:      if (scl_fall && byte_full) state_nx = S_RD_ACK;
                S_RD_ACK:  if (scl_fall) state_nx = ack_n ? S_IGNORE : S_RD;
`endif
                default:   state_nx = state;
            endcase
        end
    end

    always_comb begin
        sda_low = 1'b0;
        case (state)
            S_DEV_ACK, S_SUB_ACK, S_DAT_ACK: sda_low = 1'b1;
`ifdef I2C_SLAVE_READ_EN
            S_RD:                            sda_low = !tx[7];
`endif
            default:                         sda_low = 1'b0;
        endcase
    end

    assign I2C_SDAT = sda_low ? 1'b0 : 1'bz;

`ifdef I2C_SLAVE_READ_EN
    assign counting = (state == S_DEV) || (state == S_SUB) || (state == S_DAT) || (state == S_RD);
`else
    assign counting = (state == S_DEV) || (state == S_SUB) || (state == S_DAT);
`endif
    // The write commits on the same edge that enters DAT_ACK, so strobe and ACK drive coincide.
    assign wr_en = (state == S_DAT) && (state_nx == S_DAT_ACK);

    always_ff @(posedge CLOCK_50) begin
        if (!iRST_N) begin
            bit_cnt   <= '0;
            byte_full <= 1'b0;
            shreg     <= '0;
            ptr       <= '0;
            oWR_STB   <= 1'b0;
            oWR_ADDR  <= '0;
            oWR_DATA  <= '0;
            oBUSY     <= 1'b0;
            oRD_DATA  <= '0;
            for (int unsigned i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else begin
            oWR_STB <= wr_en;
            if (start_det || (state_nx != state)) begin
                bit_cnt   <= '0;
                byte_full <= 1'b0;
            end else if (scl_rise && counting && !byte_full) begin
                shreg     <= {shreg[6:0], sda};
                bit_cnt   <= bit_cnt + 3'd1;
                byte_full <= (bit_cnt == 3'd7);
            end
            if ((state == S_SUB) && (state_nx == S_SUB_ACK)) ptr <= shreg[PW-1:0];
            if (wr_en) begin
                regs[ptr] <= shreg;
                oWR_ADDR  <= 8'(ptr);
                oWR_DATA  <= shreg;
                ptr       <= ptr_inc;
            end
`ifdef I2C_SLAVE_READ_EN
            if ((state == S_RD_ACK) && (state_nx == S_RD)) ptr <= ptr_inc;
`endif
            if (stop_det)                                       oBUSY <= 1'b0;
            else if ((state == S_DEV) && (state_nx == S_DEV_ACK)) oBUSY <= 1'b1;
            else if ((state == S_DEV) && (state_nx == S_IGNORE))  oBUSY <= 1'b0;
            oRD_DATA <= ({1'b0, iRD_ADDR} < DEPTH) ? regs[iRD_ADDR[PW-1:0]] : '0;
        end
    end

`ifdef I2C_SLAVE_READ_EN
    always_ff @(posedge CLOCK_50) begin
        if (!iRST_N) begin
            rw    <= 1'b0;
            tx    <= '0;
            ack_n <= 1'b1;
        end else begin
            if ((state == S_DEV) && (state_nx == S_DEV_ACK)) rw <= shreg[0];
            if ((state == S_DEV_ACK) && (state_nx == S_RD))     tx <= regs[ptr];
            else if ((state == S_RD_ACK) && (state_nx == S_RD)) tx <= regs[ptr_inc];
            else if ((state == S_RD) && scl_fall)               tx <= {tx[6:0], 1'b0};
            if ((state == S_RD_ACK) && scl_rise) ack_n <= sda;
        end
    end
`endif

endmodule
